two_port_mem_clr: RTL and testbench



---
 rtl/two_port_mem_clr_pkg.sv | 26 ++
 rtl/two_port_mem_clr_rdpipe.sv | 51 +++++
 rtl/two_port_mem_clr.sv | 114 +++++++++++
 tb/tb_two_port_mem_clr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/two_port_mem_clr_pkg.sv
// Shared state encoding, sizing helpers and the read-latency legality check
// for the two_port_mem_clr behavioural memory.
`ifndef TWO_PORT_MEM_CLR_LAT_OK
`define TWO_PORT_MEM_CLR_LAT_OK(lat) (((lat) == 1) || ((lat) == 2))
`endif

package two_port_mem_clr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int clogb2(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int laneWidth(input int width, input int writeMask);
    return width / writeMask;
  endfunction

endpackage

// File: rtl/two_port_mem_clr_rdpipe.sv
// Read-side output pipeline: first data/valid register, plus an optional
// second register stage when the read latency is 2.
module two_port_mem_clr_rdpipe #(
  parameter int width       = 8,
  parameter int readLatency = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic [width-1:0] i_data,
  output logic             o_vld,
  output logic [width-1:0] o_data
);

  logic             r_vld_p1;
  logic [width-1:0] r_data_p1;

  // Stage p1: capture the array word; data holds when no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= i_vld;
      if (i_vld) r_data_p1 <= i_data;
    end
  end

  if (readLatency == 2) begin : g_lat2
    logic             r_vld_p2;
    logic [width-1:0] r_data_p2;

    // Stage p2: extra output register; reset drops any read still in flight.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_vld_p2  <= 1'b0;
        r_data_p2 <= '0;
      end else begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_data_p2 <= r_data_p1;
      end
    end

    assign o_vld  = r_vld_p2;
    assign o_data = r_data_p2;
  end else begin : g_lat1
    assign o_vld  = r_vld_p1;
    assign o_data = r_data_p1;
  end

endmodule

// File: rtl/two_port_mem_clr.sv
// Portable two-port memory with lane-masked writes and a post-reset clear
// sequencer. Define TWO_PORT_MEM_CLR_BYPASS_EN to forward same-cycle writes to reads.
module two_port_mem_clr
  import two_port_mem_clr_pkg::*;
#(
  parameter int               addresses    = 32,
  parameter int               width        = 8,
  parameter int               writeMask    = 1,
  parameter int               readLatency  = 1,
  parameter logic [width-1:0] clearValue   = '0,
  localparam int              addressWidth = clogb2(addresses)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addressWidth-1:0] writeAddress,
  input  logic [writeMask-1:0]    writeEnable,
  input  logic [width-1:0]        writeData,
  input  logic [addressWidth-1:0] readAddress,
  input  logic                    readEnable,
  output logic [width-1:0]        readData,
  output logic                    readValid,
  output logic                    busy
);

  localparam int                    LW        = laneWidth(width, writeMask);
  localparam logic [addressWidth:0] DEPTH     = (addressWidth + 1)'(addresses);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(addresses - 1);

  if ((width % writeMask) != 0) begin : g_bad_mask
    $error("two_port_mem_clr: width %0d is not a multiple of writeMask %0d", width, writeMask);
  end
  if (!`TWO_PORT_MEM_CLR_LAT_OK(readLatency)) begin : g_bad_lat
    $error("two_port_mem_clr: readLatency %0d must be 1 or 2", readLatency);
  end

  logic [width-1:0]        r_mem [addresses];
  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [addressWidth-1:0] r_clear_addr;
  logic [addressWidth-1:0] w_clear_addr_nxt;
  logic                    w_wr_hit;
  logic                    w_rd_vld;
  logic                    w_rd_in_range;
  logic [width-1:0]        w_wr_word;
  logic [width-1:0]        w_rd_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_clear_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_addr <= w_clear_addr_nxt;
    end
  end

  // The sweep ends at addresses-1 even when the depth is not a power of two.
  always_comb begin
    w_state_nxt      = r_state;
    w_clear_addr_nxt = r_clear_addr;
    if (r_state == CLEAR) begin
      w_clear_addr_nxt = r_clear_addr + addressWidth'(1);
      if (r_clear_addr == LAST_ADDR) begin
        w_state_nxt      = IDLE;
        w_clear_addr_nxt = '0;
      end
    end
  end

  assign busy = (r_state == CLEAR);

  assign w_wr_hit      = (r_state == IDLE) && (|writeEnable) && ({1'b0, writeAddress} < DEPTH);
  assign w_rd_vld      = (r_state == IDLE) && readEnable;
  assign w_rd_in_range = ({1'b0, readAddress} < DEPTH);

  always_comb begin
    w_wr_word = r_mem[writeAddress];
    for (int i = 0; i < writeMask; i++) begin
      if (writeEnable[i]) w_wr_word[i*LW +: LW] = writeData[i*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clear_addr] <= clearValue;
    end else if (w_wr_hit) begin
      r_mem[writeAddress] <= w_wr_word;
    end
  end

  // Out-of-range reads see the clear pattern rather than undefined storage.
  always_comb begin
    w_rd_word = clearValue;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[readAddress];
`ifdef TWO_PORT_MEM_CLR_BYPASS_EN
      if (w_wr_hit && (writeAddress == readAddress)) w_rd_word = w_wr_word;
`endif
    end
  end

  two_port_mem_clr_rdpipe #(
    .width      (width),
    .readLatency(readLatency)
  ) u_rdpipe (
    .i_clk  (clk),
    .i_reset(reset),
    .i_vld  (w_rd_vld),
    .i_data (w_rd_word),
    .o_vld  (readValid),
    .o_data (readData)
  );

endmodule

// File: tb/tb_two_port_mem_clr.sv
// Scoreboard bench: two instances (read latency 1 and 2) share one stimulus
// stream and are checked against an array-based reference memory.
module tb_two_port_mem_clr;

  localparam int              ADDRS = 20;
  localparam int              W     = 16;
  localparam int              M     = 2;
  localparam int              AW    = 5;
  localparam logic [W-1:0]    CLR   = 16'hA5C3;
`ifdef TWO_PORT_MEM_CLR_BYPASS_EN
  localparam bit              BYPASS = 1'b1;
`else
  localparam bit              BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic [M-1:0]  we = '0;
  logic [W-1:0]  wd = '0;
  logic          re = 1'b0;
  logic [W-1:0]  rd1, rd2;
  logic          rv1, rv2, busy1, busy2;

  two_port_mem_clr #(
    .addresses(ADDRS), .width(W), .writeMask(M), .readLatency(1), .clearValue(CLR)
  ) u_lat1 (
    .clk(clk), .reset(reset), .writeAddress(wa), .writeEnable(we), .writeData(wd),
    .readAddress(ra), .readEnable(re), .readData(rd1), .readValid(rv1), .busy(busy1)
  );

  two_port_mem_clr #(
    .addresses(ADDRS), .width(W), .writeMask(M), .readLatency(2), .clearValue(CLR)
  ) u_lat2 (
    .clk(clk), .reset(reset), .writeAddress(wa), .writeEnable(we), .writeData(wd),
    .readAddress(ra), .readEnable(re), .readData(rd2), .readValid(rv2), .busy(busy2)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q1[$];
  exp_t         q2[$];
  logic [W-1:0] model[ADDRS];
  int           clr_left  = 0;
  logic         exp_busy  = 1'b1;
  bit           started   = 1'b0;
  int           edges     = 0;
  logic [W-1:0] hold1     = '0;
  logic [W-1:0] hold2     = '0;
  int           total     = 0;
  int           bad       = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edges);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [M-1:0] en);
    logic [W-1:0] mask;
    mask = {{8{en[1]}}, {8{en[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a, input logic [M-1:0] w_en,
                                              input logic [AW-1:0] w_a, input logic [W-1:0] w_d);
    if (a >= ADDRS) return CLR;
    if (BYPASS && (w_en != '0) && (w_a == a)) return merge(model[a], w_d, w_en);
    return model[a];
  endfunction

  // One clock of stimulus; the reference model advances on the same edge.
  task automatic cycle(input logic r, input logic [M-1:0] w_en, input logic [AW-1:0] w_a,
                       input logic [W-1:0] w_d, input logic r_en, input logic [AW-1:0] r_a);
    exp_t e;
    @(negedge clk);
    reset = r; we = w_en; wa = w_a; wd = w_d; re = r_en; ra = r_a;
    @(posedge clk);
    edges++;
    if (r) begin
      q1.delete();
      q2.delete();
      for (int i = 0; i < ADDRS; i++) model[i] = CLR;
      clr_left = ADDRS;
      hold1    = '0;
      hold2    = '0;
      exp_busy = 1'b1;
      started  = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_busy = (clr_left > 0);
    end else begin
      if (r_en) begin
        e.data = model_read(r_a, w_en, w_a, w_d);
        e.due  = edges;
        q1.push_back(e);
        e.due  = edges + 1;
        q2.push_back(e);
      end
      if ((w_en != '0) && (w_a < ADDRS)) model[w_a] = merge(model[w_a], w_d, w_en);
      exp_busy = 1'b0;
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [W-1:0] d);
    exp_t         e;
    int           n;
    logic [W-1:0] h;
    string        sfx;
    sfx = (id == 0) ? "_l1" : "_l2";
    n   = (id == 0) ? q1.size() : q2.size();
    h   = (id == 0) ? hold1 : hold2;
    if (v) begin
      if (n == 0) begin
        check({"vld_unexpected", sfx}, W'(v), '0);
        h = d;
      end else begin
        if (id == 0) e = q1.pop_front();
        else         e = q2.pop_front();
        check({"rd_data", sfx}, d, e.data);
        check({"rd_edge", sfx}, W'(edges), W'(e.due));
        h = e.data;
      end
    end else begin
      if (n > 0) begin
        e = (id == 0) ? q1[0] : q2[0];
        if (e.due <= edges) begin
          check({"vld_missing", sfx}, W'(v), W'(1));
          if (id == 0) void'(q1.pop_front());
          else         void'(q2.pop_front());
        end
      end
      check({"rd_hold", sfx}, d, h);
    end
    if (id == 0) hold1 = h;
    else         hold2 = h;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("busy_l1", W'(busy1), W'(exp_busy));
      check("busy_l2", W'(busy2), W'(exp_busy));
      mon(0, rv1, rd1);
      mon(1, rv2, rd2);
    end
  end

  initial begin
    // Clear after reset, with requests that must be ignored.
    cycle(1'b1, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < ADDRS; i++) cycle(1'b0, 2'b11, 5'd5, 16'hFFFF, 1'b1, 5'd5);
    for (int a = 0; a < 32; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a));

    // Masked write.
    cycle(1'b0, 2'b11, 5'd3, 16'h1234, 1'b0, '0);
    cycle(1'b0, 2'b10, 5'd3, 16'hABCD, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 5'd3);

    // Dropped out-of-range write.
    cycle(1'b0, 2'b11, 5'd25, 16'hDEAD, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 5'd25);

    // Same-address collisions, full and partial lane.
    cycle(1'b0, 2'b11, 5'd7, 16'h0011, 1'b0, '0);
    cycle(1'b0, 2'b11, 5'd7, 16'h0055, 1'b1, 5'd7);
    cycle(1'b0, 2'b01, 5'd7, 16'h7766, 1'b1, 5'd7);
    cycle(1'b0, '0, '0, '0, 1'b1, 5'd7);

    // Back-to-back reads.
    for (int a = 1; a <= 3; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a));
    cycle(1'b0, '0, '0, '0, 1'b0, '0);

    for (int i = 0; i < 300; i++)
      cycle(1'b0, M'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), W'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));

    // Reset with a read in flight, then again mid-clear.
    cycle(1'b0, '0, '0, '0, 1'b1, 5'd4);
    cycle(1'b1, '0, '0, '0, 1'b1, 5'd4);
    for (int i = 0; i < 10; i++) cycle(1'b0, 2'b11, 5'd9, 16'h5A5A, 1'b1, 5'd9);
    cycle(1'b1, '0, '0, '0, 1'b0, '0);
    for (int a = 0; a < ADDRS + 4; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a % ADDRS));

    for (int i = 0; i < 200; i++)
      cycle(1'b0, M'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), W'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));

    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("drain_l1", W'(q1.size()), '0);
    check("drain_l2", W'(q2.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
